sram_arbiter: RTL

- Owns the single external SRAM and shares it between two requesters: the VGA scan-out reader (port 0) and the text/font renderer writer (port 1).
- Sits between the display renderer, the VGA timing block and the SRAM pads.
- Scan-out has priority. The renderer is guaranteed forward progress through a bounded-burst fairness counter.
- Each requester sees a req/done handshake, matching the existing renderer SRAM request/result contract.

---
 rtl/sram_arbiter_pkg.sv | 28 ++
 rtl/sram_arb_fairness.sv | 36 +++
 rtl/sram_arbiter.sv | 135 +++++++++++++
 3 files changed

// File: rtl/sram_arbiter_pkg.sv
// rtl/sram_arbiter_pkg.sv - shared types and widths for the SRAM arbiter
package sram_arbiter_pkg;

  localparam int SRAM_ADDR_WIDTH = 20;
  localparam int SRAM_DATA_WIDTH = 32;

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_LATCH,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD
  } SramArbState_t;

  typedef struct packed {
    logic [SRAM_ADDR_WIDTH-1:0]   address;
    logic [SRAM_DATA_WIDTH-1:0]   wdata;
    logic [SRAM_DATA_WIDTH/8-1:0] be;
    logic                         req;
  } SramPortReq_t;

  // Arbitration happens while idle and in the final cycle of every access.
  function automatic logic isArbPoint(SramArbState_t s);
    return (s == IDLE) || (s == RD_LATCH) || (s == WR_HOLD);
  endfunction

endpackage

// File: rtl/sram_arb_fairness.sv
// rtl/sram_arb_fairness.sv - scan-out priority grant with a bounded VGA burst so the renderer
// always makes progress
module sram_arb_fairness #(
  parameter int MAX_VGA_BURST = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic vga_req,
  input  logic rnd_req,
  input  logic arb_point,
  output logic grant_vga,
  output logic grant_rnd
);

  logic [3:0] burstCnt;
  logic       burstFull;

  assign burstFull = (burstCnt >= 4'(MAX_VGA_BURST));

  always_comb begin
    grant_vga = 1'b0;
    grant_rnd = 1'b0;
    if (arb_point) begin
      if (vga_req && !(rnd_req && burstFull)) grant_vga = 1'b1;
      else if (rnd_req)                       grant_rnd = 1'b1;
    end
  end

  // Only VGA grants that make the renderer wait count toward the burst.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                       burstCnt <= '0;
    else if (grant_vga && rnd_req)  burstCnt <= burstCnt + 4'd1;
    else if (grant_vga || grant_rnd) burstCnt <= '0;
  end

endmodule

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - shares one async SRAM between VGA scan-out reads and renderer writes.
// Defining SRAM_ARBITER_STATS_EN adds access counters and a worst-case renderer stall register.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int ADDR_W        = SRAM_ADDR_WIDTH,
  parameter int DATA_W        = SRAM_DATA_WIDTH,
  parameter int MAX_VGA_BURST = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  vga_req,
  input  logic [ADDR_W-1:0]     vga_addr,
  output logic [DATA_W-1:0]     vga_rdata,
  output logic                  vga_done,
  input  logic                  rnd_req,
  input  logic [ADDR_W-1:0]     rnd_addr,
  input  logic [DATA_W-1:0]     rnd_wdata,
  input  logic [DATA_W/8-1:0]   rnd_be,
  output logic                  rnd_done,
  output logic [ADDR_W-1:0]     sram_addr,
  output logic [DATA_W-1:0]     sram_dq_o,
  output logic                  sram_dq_oe,
  input  logic [DATA_W-1:0]     sram_dq_i,
  output logic                  sram_ce_n,
  output logic                  sram_oe_n,
  output logic                  sram_we_n,
  output logic [DATA_W/8-1:0]   sram_be_n
`ifdef SRAM_ARBITER_STATS_EN
  ,
  input  logic                  stat_clr,
  output logic [31:0]           stat_vga_cnt,
  output logic [31:0]           stat_rnd_cnt,
  output logic [7:0]            stat_stall_max
`endif
);

  SramArbState_t state, nextState;
  logic          arbPoint, grantVga, grantRnd;

  assign arbPoint = isArbPoint(state);

  sram_arb_fairness #(.MAX_VGA_BURST(MAX_VGA_BURST)) u_fairness (
    .clk       (clk),
    .rst       (rst),
    .vga_req   (vga_req),
    .rnd_req   (rnd_req),
    .arb_point (arbPoint),
    .grant_vga (grantVga),
    .grant_rnd (grantRnd)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nextState;
  end

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE, RD_LATCH, WR_HOLD:
        nextState = grantVga ? RD_ADDR : (grantRnd ? WR_SETUP : IDLE);
      RD_ADDR:  nextState = RD_LATCH;
      WR_SETUP: nextState = WR_PULSE;
      WR_PULSE: nextState = WR_HOLD;
      default:  nextState = IDLE;
    endcase
  end

  // Pins are registered from nextState so every strobe is glitch-free and aligned to its state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sram_addr  <= '0;
      sram_dq_o  <= '0;
      sram_dq_oe <= 1'b0;
      sram_ce_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
      sram_be_n  <= '1;
      vga_rdata  <= '0;
      vga_done   <= 1'b0;
      rnd_done   <= 1'b0;
    end else begin
      sram_ce_n  <= (nextState == IDLE);
      sram_oe_n  <= !((nextState == RD_ADDR) || (nextState == RD_LATCH));
      sram_we_n  <= (nextState != WR_PULSE);
      sram_dq_oe <= (nextState == WR_SETUP) || (nextState == WR_PULSE) || (nextState == WR_HOLD);
      vga_done   <= (state == RD_LATCH);
      rnd_done   <= (state == WR_HOLD);
      if (state == RD_LATCH) vga_rdata <= sram_dq_i;
      if (nextState == RD_ADDR) begin
        sram_addr <= vga_addr;
        sram_be_n <= '0;
      end else if (nextState == WR_SETUP) begin
        sram_addr <= rnd_addr;
        sram_dq_o <= rnd_wdata;
        sram_be_n <= ~rnd_be;
      end else if (nextState == IDLE) begin
        sram_be_n <= '1;
      end
    end
  end

`ifdef SRAM_ARBITER_STATS_EN
  logic [7:0] rndWait;
  logic       inWrite;

  assign inWrite = (state == WR_SETUP) || (state == WR_PULSE) || (state == WR_HOLD);

  // rndWait counts renderer cycles spent waiting; it is sampled into the maximum at grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rndWait        <= '0;
      stat_vga_cnt   <= '0;
      stat_rnd_cnt   <= '0;
      stat_stall_max <= '0;
    end else begin
      if (grantRnd)
        rndWait <= '0;
      else if (rnd_req && !inWrite && rndWait != 8'hFF)
        rndWait <= rndWait + 8'd1;
      if (stat_clr) begin
        stat_vga_cnt   <= '0;
        stat_rnd_cnt   <= '0;
        stat_stall_max <= '0;
      end else begin
        stat_vga_cnt <= stat_vga_cnt + {31'd0, vga_done};
        stat_rnd_cnt <= stat_rnd_cnt + {31'd0, rnd_done};
        if (grantRnd && rndWait > stat_stall_max) stat_stall_max <= rndWait;
      end
    end
  end
`endif

endmodule
